// File: rtl/dekatron_pkg.sv
// Shared types and helpers for the dekatron step sequencer.
//   state_e   : sequencer phase (IDLE, PH1, PH2, SETTLE)
//   bcd_t     : one decimal digit in BCD
//   bcd_step  : +/-1 modulo 10 with wrap flag
package dekatron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PH1    = 2'd1,
    ST_PH2    = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef struct packed {
    logic carry;
    bcd_t value;
  } bcd_step_t;

  // One tube position up or down; carry marks the 9->0 / 0->9 wrap.
  function automatic bcd_step_t bcd_step(input bcd_t v, input logic dec);
    bcd_step_t r;
    r.carry = 1'b0;
    if (dec) begin
      if (v == 4'd0) begin
        r.value = BCD_MAX;
        r.carry = 1'b1;
      end else begin
        r.value = v - 4'd1;
      end
    end else begin
      if (v >= BCD_MAX) begin
        r.value = 4'd0;
        r.carry = 1'b1;
      end else begin
        r.value = v + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter used for guide-phase and settle timing.
//   clk_i, rst_i  : clock, async active-high reset
//   load_i        : load load_val_i this edge (takes priority over counting)
//   load_val_i    : cycles remaining minus one
//   done_o        : combinational, high while the count is zero
module pulse_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/dekatron_step_sequencer.sv
// Two-phase guide sequencer for one dekatron tube with BCD position tracking.
//   clk_i, rst_i  : clock, async active-high reset
//   request_i     : step request, sampled while ready_o=1
//   dec_i         : step direction (0 inc, 1 dec), sampled with request_i
//   set_i, in_i   : load position from in_i (ignored if in_i > 9), IDLE only
//   ready_o       : combinational, high in IDLE
//   guide1_o/2_o  : registered guide drives, never both high
//   out_o         : current BCD position
//   carry_o       : one-cycle pulse on wrap
module dekatron_step_sequencer
  import dekatron_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       request_i,
  input  logic       dec_i,
  input  logic       set_i,
  input  logic [3:0] in_i,
  output logic       ready_o,
  output logic       guide1_o,
  output logic       guide2_o,
  output logic [3:0] out_o,
  output logic       carry_o
);

  localparam int unsigned TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_e      state_q, state_d;
  logic        dec_q, dec_d;
  bcd_t        out_q, out_d;
  logic        carry_q, carry_d;
  logic        guide1_q, guide1_d;
  logic        guide2_q, guide2_d;
  logic        tmr_load;
  logic [TW-1:0] tmr_val;
  logic        tmr_done;
  bcd_step_t   step_res;

  pulse_timer #(.W(TW)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign step_res = bcd_step(out_q, dec_q);

  // Next-state, timer control and guide decode.
  always_comb begin
    state_d  = state_q;
    dec_d    = dec_q;
    out_d    = out_q;
    carry_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (set_i) begin
          if (in_i <= BCD_MAX) out_d = in_i;
        end else if (request_i) begin
          dec_d    = dec_i;
          state_d  = ST_PH1;
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYCLES - 1);
        end
      end
      ST_PH1: begin
        if (tmr_done) begin
          state_d  = ST_PH2;
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYCLES - 1);
        end
      end
      ST_PH2: begin
        if (tmr_done) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETTLE_CYCLES - 1);
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          out_d   = step_res.value;
          carry_d = step_res.carry;
          // A request held across the completing edge chains straight
          // into the next step so back-to-back steps have no dead cycle.
          if (request_i && !set_i) begin
            dec_d    = dec_i;
            state_d  = ST_PH1;
            tmr_load = 1'b1;
            tmr_val  = TW'(PULSE_CYCLES - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Guides decoded from the next state so the registered drives are glitch-free.
    guide1_d = ((state_d == ST_PH1) && !dec_d) || ((state_d == ST_PH2) && dec_d);
    guide2_d = ((state_d == ST_PH1) && dec_d)  || ((state_d == ST_PH2) && !dec_d);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      dec_q    <= 1'b0;
      out_q    <= 4'd0;
      carry_q  <= 1'b0;
      guide1_q <= 1'b0;
      guide2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dec_q    <= dec_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
      guide1_q <= guide1_d;
      guide2_q <= guide2_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign guide1_o = guide1_q;
  assign guide2_o = guide2_q;
  assign out_o    = out_q;
  assign carry_o  = carry_q;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Directed bench for dekatron_step_sequencer (P=2, S=1, step = 5 cycles).
module tb_dekatron_step_sequencer;

  localparam int unsigned P    = 2;
  localparam int unsigned S    = 1;
  localparam int unsigned STEP = 2 * P + S;

  logic       clk = 1'b0;
  logic       rst;
  logic       request;
  logic       dec;
  logic       set;
  logic [3:0] in_v;
  logic       ready;
  logic       guide1;
  logic       guide2;
  logic [3:0] out_v;
  logic       carry;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic overlap_seen = 1'b0;

  dekatron_step_sequencer #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .request_i (request),
    .dec_i     (dec),
    .set_i     (set),
    .in_i      (in_v),
    .ready_o   (ready),
    .guide1_o  (guide1),
    .guide2_o  (guide2),
    .out_o     (out_v),
    .carry_o   (carry)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (guide1 && guide2) overlap_seen = 1'b1;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Issue one single-cycle request and follow the step to completion.
  task automatic run_step(input logic d, input logic [3:0] exp_out, input logic exp_carry);
    logic first, second;
    request = 1'b1;
    dec     = d;
    @(negedge clk);
    request = 1'b0;
    for (int c = 1; c <= int'(STEP); c++) begin
      first  = (c <= int'(P));
      second = (c > int'(P)) && (c <= int'(2 * P));
      chk($sformatf("g1_c%0d", c), 8'(guide1), 8'(d ? second : first));
      chk($sformatf("g2_c%0d", c), 8'(guide2), 8'(d ? first : second));
      chk($sformatf("busy_c%0d", c), 8'(ready), 8'd0);
      @(negedge clk);
    end
    chk("step_out", 8'(out_v), 8'(exp_out));
    chk("step_carry", 8'(carry), 8'(exp_carry));
    chk("step_ready", 8'(ready), 8'd1);
  endtask

  task automatic do_set(input logic [3:0] v);
    set  = 1'b1;
    in_v = v;
    @(negedge clk);
    set  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; request = 1'b0; dec = 1'b0; set = 1'b0; in_v = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 8'(ready), 8'd1);
    chk("rst_out", 8'(out_v), 8'd0);
    chk("rst_g1", 8'(guide1), 8'd0);
    chk("rst_g2", 8'(guide2), 8'd0);
    chk("rst_carry", 8'(carry), 8'd0);

    // Plain increment 0 -> 1.
    run_step(1'b0, 4'd1, 1'b0);

    // Wrap up from 9, carry lasts exactly one cycle, then wrap down.
    do_set(4'd9);
    chk("set9_out", 8'(out_v), 8'd9);
    chk("set9_carry", 8'(carry), 8'd0);
    run_step(1'b0, 4'd0, 1'b1);
    @(negedge clk);
    chk("carry_drop", 8'(carry), 8'd0);
    run_step(1'b1, 4'd9, 1'b1);
    @(negedge clk);

    // Request held for 12 edges from 0: accepts at E0, E5, E10.
    do_set(4'd0);
    request = 1'b1; dec = 1'b0;
    repeat (12) @(negedge clk);
    request = 1'b0;
    chk("held_out", 8'(out_v), 8'd2);
    chk("held_ready", 8'(ready), 8'd0);
    chk("held_g1", 8'(guide1), 8'd1);
    repeat (4) @(negedge clk);
    chk("held_out3", 8'(out_v), 8'd3);
    chk("held_ready3", 8'(ready), 8'd1);

    // Set beats Request; out-of-range Set is ignored.
    set = 1'b1; request = 1'b1; in_v = 4'd5;
    @(negedge clk);
    set = 1'b0; request = 1'b0;
    chk("setreq_out", 8'(out_v), 8'd5);
    chk("setreq_ready", 8'(ready), 8'd1);
    @(negedge clk);
    chk("setreq_g1", 8'(guide1), 8'd0);
    chk("setreq_g2", 8'(guide2), 8'd0);
    chk("setreq_ready2", 8'(ready), 8'd1);
    do_set(4'd12);
    chk("set12_out", 8'(out_v), 8'd5);

    // Request/Set pulsed during PH2 are ignored.
    request = 1'b1; dec = 1'b0;
    @(negedge clk);
    request = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ph2_g2", 8'(guide2), 8'd1);
    request = 1'b1; set = 1'b1; in_v = 4'd0; dec = 1'b1;
    @(negedge clk);
    request = 1'b0; set = 1'b0;
    chk("ph2_out_hold", 8'(out_v), 8'd5);
    repeat (2) @(negedge clk);
    chk("ph2_out", 8'(out_v), 8'd6);
    chk("ph2_carry", 8'(carry), 8'd0);
    chk("ph2_ready", 8'(ready), 8'd1);
    @(negedge clk);
    chk("ph2_noqueue_ready", 8'(ready), 8'd1);
    chk("ph2_noqueue_g", 8'({guide1, guide2}), 8'd0);

    // Asynchronous reset mid-PH1.
    request = 1'b1; dec = 1'b0;
    @(negedge clk);
    request = 1'b0;
    chk("abort_g1_pre", 8'(guide1), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_g1", 8'(guide1), 8'd0);
    chk("abort_g2", 8'(guide2), 8'd0);
    chk("abort_ready", 8'(ready), 8'd1);
    chk("abort_out", 8'(out_v), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_out_after", 8'(out_v), 8'd0);
    chk("abort_carry", 8'(carry), 8'd0);
    chk("abort_ready_after", 8'(ready), 8'd1);

    chk("no_overlap", 8'(overlap_seen), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/dekatron_step_sequencer.md
# dekatron_step_sequencer

Sequences the two guide-electrode phases that advance one dekatron counting tube by one position, up or down, and tracks the tube's decimal position (0–9) in a BCD register. It sits between the instruction/IP control logic of the dekatron PC and the tube driver gates. It grants one step request at a time through a Ready/Request handshake and flags wrap-around for cascading to the next decade.

## Interface
- PULSE_CYCLES, 2: clock cycles each guide phase is held active (≥1)
- SETTLE_CYCLES, 1: clock cycles of glow-settle gap after the second phase (≥1)
- Clk  in  1  system clock; all state updates on the rising edge
- Rst  in  1  asynchronous, active-high reset
- Request  in  1  step request; sampled only when Ready=1
- Dec  in  1  direction for the request: 0 = increment, 1 = decrement; sampled with Request
- Set  in  1  synchronous load of position from In; honoured only when Ready=1
- In  in  4  BCD load value
- Ready  out  1  high in IDLE; block accepts Request/Set
- Guide1  out  1  first-guide drive (registered)
- Guide2  out  1  second-guide drive (registered)
- Out  out  4  current BCD position
- Carry  out  1  one-cycle pulse on wrap 9→0 (inc) or 0→9 (dec)

## Operation
- States: IDLE, PH1, PH2, SETTLE; one-phase timer counts down within each state.
- IDLE: Ready=1, guides 0. Set=1 with In≤9 loads Out←In on the edge. Set=1 with In>9 is ignored, Out unchanged. Set and Request together: Set wins, Request dropped.
- IDLE with Request=1, Set=0: latch Dec. Next state PH1 with timer=PULSE_CYCLES-1.
- PH1: increment drives Guide1=1; decrement drives Guide2=1. Timer expiry → PH2.
- PH2: the other guide =1 for PULSE_CYCLES cycles. Timer expiry → SETTLE with timer=SETTLE_CYCLES-1.
- SETTLE: both guides 0. On expiry, Out updates ±1 mod 10, Carry=1 for that one cycle (wrap only), and the state returns to IDLE.
- Guide1 and Guide2 are never both 1; a registered decode guarantees no glitches.
- Request/Set/Dec/In while not IDLE: ignored, not queued.
- Arithmetic: 4-bit BCD. Inc 9→0 with Carry. Dec 0→9 with Carry. Otherwise ±1, Carry=0.
- Rst at any time, including mid-phase: state IDLE, Out=0, Guide1=Guide2=0, Carry=0, Ready=1. An aborted step does not change Out.

## Timing
- Ready is a combinational decode of state==IDLE. All other outputs are registered.
- Acceptance edge E0 (Request=1 and Ready=1):
  - Ready=0 from E0.
  - First guide high for cycles 1..P after E0.
  - Second guide high for cycles P+1..2P.
  - Gap for 2P+1..2P+S.
  - Out/Carry update and Ready=1 at edge E0+2P+S.
- Step latency is 2·PULSE_CYCLES+SETTLE_CYCLES cycles. Default: 5.
- Back-to-back throughput: a Request held high is re-accepted on the same edge Ready returns. One step therefore takes 2P+S cycles, with no dead cycle.
- Set latency: 1 cycle; Out valid after the edge. Carry unaffected by Set.
- Timer width: $clog2(max(PULSE_CYCLES,SETTLE_CYCLES)+1).

## Structure
- Shared package dekatron_pkg: state enum (IDLE, PH1, PH2, SETTLE), BCD_MAX=4'd9, BCD type.
- Sub-module pulse_timer: loadable down-counter with a done flag, reused for phase and settle timing.
- The BCD ±1-with-wrap logic stays inline as a function in the package.

## Test plan
- Reset, then Request=1, Dec=0 one cycle (P=2, S=1) -> Guide1 high cycles 1–2, Guide2 high cycles 3–4, Out 0→1 at edge 5, Carry=0, Ready high at edge 5.
- Set=1, In=9, then Request inc -> Out=0, Carry=1 for exactly one cycle. Then Request dec -> Guide2 before Guide1, Out=9, Carry=1.
- Request held high for 12 cycles from Out=0 -> exactly 2 steps completed plus 2 cycles into a third (Out=2). The guides are never simultaneously high.
- Set=1, Request=1 same cycle with In=5 -> Out=5, no guide pulses. Set with In=12 -> Out unchanged.
- Request/Set pulsed during PH2 -> ignored, and the step completes normally.
- Rst asserted asynchronously mid-PH1 -> guides drop immediately, Out=0, Ready=1, and no Carry.
